// File: rtl/if_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// feeds the IF/ID pipeline register, buffers a response that arrives while
// decode is stalled, and drops responses made stale by a decode redirect.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        control_j,
    input  logic [63:0] pc_j,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic [63:0] req_addr, req_addr_next;
    logic [63:0] hold_pc, hold_pc_next;
    logic [31:0] hold_data, hold_data_next;
    logic [63:0] pipe_pc_next;
    logic [31:0] pipe_data_next;
    logic        pipe_valid_next;
    logic [63:0] pc_plus4;

    // Sequential PC wraps modulo 2^64 by plain truncation of the adder.
    assign pc_plus4  = pc + 64'd4;
    assign imem_req  = (state == REQ) || (state == DISCARD);
    assign imem_addr = req_addr;

    // Next-state, fetch-address and IF/ID update logic.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        req_addr_next   = req_addr;
        hold_pc_next    = hold_pc;
        hold_data_next  = hold_data;
        pipe_pc_next    = pipe_pc;
        pipe_data_next  = pipe_data;
        pipe_valid_next = pipe_valid;

        // Redirect or an idle unstalled cycle leaves a bubble; a stall holds IF/ID.
        if (control_j || !stall) begin
            pipe_data_next  = NOP_INST;
            pipe_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                state_next    = REQ;
                req_addr_next = pc;
            end

            REQ: begin
                if (control_j) begin
                    pc_next = pc_j;
                    if (imem_ack) begin
                        req_addr_next = pc_j;
                    end else begin
                        state_next = DISCARD;
                    end
                end else if (imem_ack && !stall) begin
                    pipe_pc_next    = req_addr;
                    pipe_data_next  = imem_rdata;
                    pipe_valid_next = 1'b1;
                    pc_next         = pc_plus4;
                    req_addr_next   = pc_plus4;
                end else if (imem_ack) begin
                    hold_pc_next   = req_addr;
                    hold_data_next = imem_rdata;
                    state_next     = HOLD;
                end
            end

            HOLD: begin
                if (control_j) begin
                    pc_next       = pc_j;
                    req_addr_next = pc_j;
                    state_next    = REQ;
                end else if (!stall) begin
                    pipe_pc_next    = hold_pc;
                    pipe_data_next  = hold_data;
                    pipe_valid_next = 1'b1;
                    pc_next         = pc_plus4;
                    req_addr_next   = pc_plus4;
                    state_next      = REQ;
                end
            end

            DISCARD: begin
                if (control_j) begin
                    pc_next = pc_j;
                end else if (imem_ack) begin
                    req_addr_next = pc;
                    state_next    = REQ;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= 64'h0;
            hold_pc    <= 64'h0;
            hold_data  <= 32'h0;
            pipe_pc    <= 64'h0;
            pipe_data  <= NOP_INST;
            pipe_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_addr   <= req_addr_next;
            hold_pc    <= hold_pc_next;
            hold_data  <= hold_data_next;
            pipe_pc    <= pipe_pc_next;
            pipe_data  <= pipe_data_next;
            pipe_valid <= pipe_valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand-written corner
// sequences, and a randomized run checked against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        control_j = 1'b0;
    logic [63:0] pc_j = 64'h0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [63:0] pipe_pc;
    logic [31:0] pipe_data;
    logic        pipe_valid;

    // Second instance exercising the wrap-around reset address.
    logic        reset2 = 1'b1;
    logic        zero2 = 1'b0;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic [63:0] pcj2 = 64'h0;
    logic        req2;
    logic [63:0] addr2;
    logic [63:0] ppc2;
    logic [31:0] pdata2;
    logic        pvalid2;

    int assertCount = 0;
    int failCount = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .control_j(control_j), .pc_j(pc_j),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pipe_pc(pipe_pc), .pipe_data(pipe_data),
        .pipe_valid(pipe_valid)
    );

    if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(zero2), .control_j(zero2), .pc_j(pcj2),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .pipe_pc(ppc2), .pipe_data(pdata2),
        .pipe_valid(pvalid2)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        cj;
        logic [63:0] pcj;
        logic        ack;
        logic [31:0] rdata;
        logic        expReq;
        logic [63:0] expAddr;
        logic [63:0] expPpc;
        logic [31:0] expPdata;
        logic        expPvalid;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: what the fetch unit is doing, not how.
    logic        mBoot, mActive, mDrop, mHeld;
    logic [63:0] mPc, mAddr, mHpc, mPpc;
    logic [31:0] mHdata, mPdata;
    logic        mPvalid;

    function automatic logic [31:0] imemWord(input logic [63:0] a);
        return {a[15:0], 16'h0} ^ a[47:16] ^ 32'hA5C3_0F00;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            if (failCount <= 40)
                $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [63:0] eAddr,
                            input logic [63:0] ePpc, input logic [31:0] ePdata, input logic ePvalid);
        checkOutput({tag, " imem_req"}, {63'h0, imem_req}, {63'h0, eReq});
        checkOutput({tag, " imem_addr"}, imem_addr, eAddr);
        checkOutput({tag, " pipe_pc"}, pipe_pc, ePpc);
        checkOutput({tag, " pipe_data"}, {32'h0, pipe_data}, {32'h0, ePdata});
        checkOutput({tag, " pipe_valid"}, {63'h0, pipe_valid}, {63'h0, ePvalid});
    endtask

    // Drive one cycle of inputs and advance to just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic c, input logic [63:0] pj,
                                 input logic a, input logic [31:0] rd);
        stall = s;
        control_j = c;
        pc_j = pj;
        imem_ack = a;
        imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mBoot = 1'b1; mActive = 1'b0; mDrop = 1'b0; mHeld = 1'b0;
        mPc = 64'h0; mAddr = 64'h0; mHpc = 64'h0; mHdata = 32'h0;
        mPpc = 64'h0; mPdata = NOP; mPvalid = 1'b0;
    endtask

    // One clock of the reference behaviour given the inputs presented.
    task automatic modelStep(input logic s, input logic c, input logic [63:0] pj,
                             input logic a, input logic [31:0] rd);
        if (c || !s) begin
            mPdata = NOP;
            mPvalid = 1'b0;
        end
        if (mBoot) begin
            mBoot = 1'b0;
            mActive = 1'b1;
            mAddr = mPc;
        end else if (mHeld) begin
            if (c) begin
                mHeld = 1'b0; mActive = 1'b1; mPc = pj; mAddr = pj;
            end else if (!s) begin
                mPpc = mHpc; mPdata = mHdata; mPvalid = 1'b1;
                mPc = mPc + 64'd4; mAddr = mPc; mHeld = 1'b0; mActive = 1'b1;
            end
        end else if (mDrop) begin
            if (c) mPc = pj;
            else if (a) begin
                mDrop = 1'b0; mAddr = mPc;
            end
        end else begin
            if (c) begin
                mPc = pj;
                if (a) mAddr = pj;
                else mDrop = 1'b1;
            end else if (a && !s) begin
                mPpc = mAddr; mPdata = rd; mPvalid = 1'b1;
                mPc = mPc + 64'd4; mAddr = mPc;
            end else if (a) begin
                mHeld = 1'b1; mHpc = mAddr; mHdata = rd; mActive = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0; control_j = 1'b0; imem_ack = 1'b0; pc_j = 64'h0;
        #1;
        checkAll("reset", 1'b0, 64'h0, 64'h0, NOP, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic addVec(input logic s, input logic c, input logic [63:0] pj, input logic a,
                          input logic [31:0] rd, input logic eReq, input logic [63:0] eAddr,
                          input logic [63:0] ePpc, input logic [31:0] ePdata, input logic ePvalid);
        vec_t v;
        v.stall = s; v.cj = c; v.pcj = pj; v.ack = a; v.rdata = rd;
        v.expReq = eReq; v.expAddr = eAddr; v.expPpc = ePpc;
        v.expPdata = ePdata; v.expPvalid = ePvalid;
        vecs.push_back(v);
    endtask

    initial begin
        logic s, c, a;
        logic [63:0] pj;
        logic [31:0] rd;

        // Directed table, starting from the first cycle after reset release.
        addVec(0, 0, 64'h0,   0, 32'h0,              1, 64'h0,   64'h0,   NOP,                1);
        vecs[0].expPvalid = 1'b0;
        addVec(0, 0, 64'h0,   1, imemWord(64'h0),    1, 64'h4,   64'h0,   imemWord(64'h0),    1);
        addVec(0, 0, 64'h0,   1, imemWord(64'h4),    1, 64'h8,   64'h4,   imemWord(64'h4),    1);
        addVec(1, 0, 64'h0,   1, imemWord(64'h8),    0, 64'h8,   64'h4,   imemWord(64'h4),    1);
        addVec(1, 0, 64'h0,   0, 32'h0,              0, 64'h8,   64'h4,   imemWord(64'h4),    1);
        addVec(1, 0, 64'h0,   0, 32'h0,              0, 64'h8,   64'h4,   imemWord(64'h4),    1);
        addVec(0, 0, 64'h0,   0, 32'h0,              1, 64'hC,   64'h8,   imemWord(64'h8),    1);
        addVec(0, 0, 64'h0,   1, imemWord(64'hC),    1, 64'h10,  64'hC,   imemWord(64'hC),    1);
        addVec(0, 1, 64'h100, 0, 32'h0,              1, 64'h10,  64'hC,   NOP,                0);
        addVec(0, 0, 64'h0,   0, 32'h0,              1, 64'h10,  64'hC,   NOP,                0);
        addVec(0, 0, 64'h0,   1, imemWord(64'h10),   1, 64'h100, 64'hC,   NOP,                0);
        addVec(0, 0, 64'h0,   1, imemWord(64'h100),  1, 64'h104, 64'h100, imemWord(64'h100),  1);
        addVec(1, 1, 64'h200, 1, imemWord(64'h104),  1, 64'h200, 64'h100, NOP,                0);
        addVec(0, 0, 64'h0,   1, imemWord(64'h200),  1, 64'h204, 64'h200, imemWord(64'h200),  1);
        addVec(0, 0, 64'h0,   0, 32'h0,              1, 64'h204, 64'h200, NOP,                0);
        addVec(1, 0, 64'h0,   1, imemWord(64'h204),  0, 64'h204, 64'h200, NOP,                0);
        addVec(1, 1, 64'h300, 0, 32'h0,              1, 64'h300, 64'h200, NOP,                0);
        addVec(0, 0, 64'h0,   1, imemWord(64'h300),  1, 64'h304, 64'h300, imemWord(64'h300),  1);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].cj, vecs[i].pcj, vecs[i].ack, vecs[i].rdata);
            checkAll($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                     vecs[i].expPpc, vecs[i].expPdata, vecs[i].expPvalid);
        end

        // Asynchronous reset in the middle of a discarded request.
        applyStimulus(0, 1, 64'h400, 0, 32'h0);
        checkAll("discard", 1'b1, 64'h304, 64'h300, NOP, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkAll("asyncrst", 1'b0, 64'h0, 64'h0, NOP, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 64'h0, 1, 32'hDEAD_BEEF);
        checkAll("lateack", 1'b1, 64'h0, 64'h0, NOP, 1'b0);
        applyStimulus(0, 0, 64'h0, 1, imemWord(64'h0));
        checkAll("restart", 1'b1, 64'h4, 64'h0, imemWord(64'h0), 1'b1);

        // Reset address at the top of the address space wraps to zero.
        @(negedge clk);
        reset2 = 1'b0;
        @(posedge clk); #1;
        checkOutput("wrap first req", {63'h0, req2}, 64'h1);
        checkOutput("wrap first addr", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        ack2 = 1'b1; rdata2 = imemWord(64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        checkOutput("wrap second addr", addr2, 64'h0);
        checkOutput("wrap pipe_pc", ppc2, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap pipe_data", {32'h0, pdata2}, {32'h0, imemWord(64'hFFFF_FFFF_FFFF_FFFC)});
        checkOutput("wrap pipe_valid", {63'h0, pvalid2}, 64'h1);
        ack2 = 1'b0;

        // Randomized run against the behavioural model.
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s = ($urandom % 4) == 0;
            c = ($urandom % 10) == 0;
            pj = {$urandom, $urandom} & ~64'h3;
            if (($urandom % 8) == 0) pj = 64'hFFFF_FFFF_FFFF_FFF8;
            if (imem_req) begin
                a = ($urandom % 2) == 0;
                rd = imemWord(imem_addr);
            end else begin
                a = ($urandom % 10) == 0;
                rd = $urandom;
            end
            stall = s; control_j = c; pc_j = pj; imem_ack = a; imem_rdata = rd;
            @(posedge clk);
            modelStep(s, c, pj, a, rd);
            #1;
            checkAll($sformatf("rand%0d", cyc), mActive, mAddr, mPpc, mPdata, mPvalid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
